// File: rtl/fetch_ctrl.sv
// F-stage fetch controller: owns the PC, runs the IM req/ack handshake and
// folds D-stage redirects into the next PC with delay-slot semantics.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_ack_i,
    input  logic [31:0] im_rdata_i,
    output logic [31:0] f_pc_o,
    output logic [31:0] f_instr_o,
    output logic        f_valid_o,
    output logic        fd_en_o,
    output logic [31:0] instr_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] cnt_q, cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; buf_q is a plain register and is reset like the rest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            buf_q     <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            buf_q     <= buf_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = cnt_q;
        im_req_o  = 1'b0;
        f_valid_o = 1'b0;
        f_instr_o = '0;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                im_req_o = 1'b1;
                if (im_ack_i) begin
                    f_valid_o = 1'b1;
                    f_instr_o = im_rdata_i;
                    if (stall_i) begin
                        buf_d   = im_rdata_i;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                f_valid_o = 1'b1;
                f_instr_o = buf_q;
                if (!stall_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        fd_en_o = f_valid_o & ~stall_i;

        // The instr moving into D is the delay slot, so a redirect seen now
        // (or one parked earlier) steers the PC after it.
        if (fd_en_o) begin
            cnt_d  = cnt_q + 32'd1;
            pend_d = 1'b0;
            if (pend_q)          pc_d = pend_pc_q;
            else if (redirect_i) pc_d = redirect_pc_i;
            else                 pc_d = pc_q + 32'd4;
        end else if (redirect_i && !stall_i && !pend_q) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc_i;
        end
    end

    assign im_addr_o   = pc_q;
    assign f_pc_o      = pc_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; expected values hand-computed.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_ack_i;
    logic [31:0] im_rdata_i;
    logic [31:0] f_pc_o;
    logic [31:0] f_instr_o;
    logic        f_valid_o;
    logic        fd_en_o;
    logic [31:0] instr_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .im_req_o      (im_req_o),
        .im_addr_o     (im_addr_o),
        .im_ack_i      (im_ack_i),
        .im_rdata_i    (im_rdata_i),
        .f_pc_o        (f_pc_o),
        .f_instr_o     (f_instr_o),
        .f_valid_o     (f_valid_o),
        .fd_en_o       (fd_en_o),
        .instr_cnt_o   (instr_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, leave 1 time unit of settling after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic ack, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] redir_pc);
        stall_i       = stall;
        im_ack_i      = ack;
        im_rdata_i    = rdata;
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check("rst_req",   {31'b0, im_req_o},  32'd0);
        check("rst_valid", {31'b0, f_valid_o}, 32'd0);
        check("rst_fden",  {31'b0, fd_en_o},   32'd0);
        check("rst_instr", f_instr_o,          32'h0);
        check("rst_pc",    f_pc_o,             32'h0000_3000);
        check("rst_cnt",   instr_cnt_o,        32'd0);

        tick();
        reset = 1'b0;
        tick();                                   // IDLE -> REQ

        // Zero-wait IM: one transfer per cycle
        drive(1'b0, 1'b1, 32'hA000_0000, 1'b0, 32'h0);
        check("t1_req0",  {31'b0, im_req_o}, 32'd1);
        check("t1_addr0", im_addr_o,         32'h0000_3000);
        check("t1_fden0", {31'b0, fd_en_o},  32'd1);
        check("t1_inst0", f_instr_o,         32'hA000_0000);
        tick();
        drive(1'b0, 1'b1, 32'hA000_0001, 1'b0, 32'h0);
        check("t1_addr1", im_addr_o,         32'h0000_3004);
        check("t1_fden1", {31'b0, fd_en_o},  32'd1);
        tick();
        drive(1'b0, 1'b1, 32'hA000_0002, 1'b0, 32'h0);
        check("t1_addr2", im_addr_o,         32'h0000_3008);
        check("t1_fden2", {31'b0, fd_en_o},  32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t1_cnt3",  instr_cnt_o,       32'd3);

        // IM with two wait states
        check("t2_val_w0", {31'b0, f_valid_o}, 32'd0);
        check("t2_req_w0", {31'b0, im_req_o},  32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_val_w1", {31'b0, f_valid_o}, 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'hB000_0000, 1'b0, 32'h0);
        check("t2_val_ack",  {31'b0, f_valid_o}, 32'd1);
        check("t2_inst_ack", f_instr_o,          32'hB000_0000);
        check("t2_pc_ack",   f_pc_o,             32'h0000_300C);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t2_cnt",  instr_cnt_o, 32'd4);
        check("t2_addr", im_addr_o,   32'h0000_3010);

        // Ack under stall goes to HOLD
        drive(1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
        check("t3_fden_stall", {31'b0, fd_en_o}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("t3_hold_req",  {31'b0, im_req_o},  32'd0);
        check("t3_hold_val",  {31'b0, f_valid_o}, 32'd1);
        check("t3_hold_inst", f_instr_o,          32'h1234_5678);
        check("t3_hold_cnt",  instr_cnt_o,        32'd4);
        tick();
        drive(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("t3_rel_fden", {31'b0, fd_en_o}, 32'd1);
        check("t3_rel_inst", f_instr_o,        32'h1234_5678);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t3_next_req",  {31'b0, im_req_o}, 32'd1);
        check("t3_next_addr", im_addr_o,         32'h0000_3014);
        check("t3_cnt",       instr_cnt_o,       32'd5);

        // Redirect while F waits: parked, later redirect ignored
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100);
        check("t4_fden_wait", {31'b0, fd_en_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3300);
        tick();
        drive(1'b0, 1'b1, 32'hC000_0000, 1'b0, 32'h0);
        check("t4_slot_fden", {31'b0, fd_en_o}, 32'd1);
        check("t4_slot_pc",   f_pc_o,           32'h0000_3014);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t4_target", im_addr_o, 32'h0000_3100);

        // Redirect under stall is not parked; same-cycle redirect from HOLD
        drive(1'b1, 1'b1, 32'hD000_0000, 1'b1, 32'h0000_3500);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3200);
        check("t5_hold_fden", {31'b0, fd_en_o}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 32'hD000_0001, 1'b0, 32'h0);
        check("t5_target", im_addr_o, 32'h0000_3200);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t5_no_pend", im_addr_o,   32'h0000_3204);
        check("t5_cnt",     instr_cnt_o, 32'd8);

        // Reset while a request is outstanding, ack arrives under reset
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0);
        check("t6_rst_req",   {31'b0, im_req_o},  32'd0);
        check("t6_rst_val",   {31'b0, f_valid_o}, 32'd0);
        check("t6_rst_instr", f_instr_o,          32'h0);
        check("t6_rst_pc",    f_pc_o,             32'h0000_3000);
        check("t6_rst_cnt",   instr_cnt_o,        32'd0);
        tick();
        check("t6_rst_edge_fden", {31'b0, fd_en_o}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'hEEEE_EEEE, 1'b0, 32'h0);
        check("t6_idle_val", {31'b0, f_valid_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t6_first_req",  {31'b0, im_req_o}, 32'd1);
        check("t6_first_addr", im_addr_o,         32'h0000_3000);
        check("t6_idle_cnt",   instr_cnt_o,       32'd0);

        // PC wraps modulo 2^32
        drive(1'b0, 1'b1, 32'hF000_0000, 1'b1, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b1, 32'hF000_0001, 1'b0, 32'h0);
        check("t7_top", im_addr_o, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("t7_wrap", im_addr_o,   32'h0000_0000);
        check("t7_cnt",  instr_cnt_o, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
